// File: rtl/snake_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : snake_cmd_master
// Function : Avalon-MM write master that queues {cmd, x, y} requests from
//            fabric sources and writes each one, packed into a 32-bit word,
//            to the snake_fpga command register.
// Revision : 1.0 - initial release
// ============================================================================
module snake_cmd_master #(
    parameter int         DEPTH      = 4,
    parameter int         GAP_CYCLES = 0,
    parameter logic [3:0] CMD_ADDR   = 4'd0,
    parameter int         CMD_OFFSET = 24,
    parameter int         X_OFFSET   = 8,
    parameter int         Y_OFFSET   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_code,
    input  logic [8:0]                 cmd_x,
    input  logic [7:0]                 cmd_y,
    output logic [3:0]                 avm_address,
    output logic                       avm_write,
    output logic [31:0]                avm_writedata,
    input  logic                       avm_waitrequest,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       busy,
    output logic [15:0]                sent_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Gap counter load value; only meaningful when GAP_CYCLES > 0.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [3:0]      gap_cnt;
    logic            full;
    logic            push;
    logic            pop;
    logic [31:0]     packed_word;

    // Ready comes only from registered occupancy, so a pop while full does
    // not open the FIFO until the following cycle.
    assign full       = (count == CW'(DEPTH));
    assign cmd_ready  = !reset && !full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign count_next = count + CW'(push) - CW'(pop);
    assign pending    = count;

    // Fields are zero-extended before shifting; all unused bits stay 0.
    assign packed_word = (32'(cmd_code) << CMD_OFFSET)
                       | (32'(cmd_x)    << X_OFFSET)
                       | (32'(cmd_y)    << Y_OFFSET);

    // FIFO storage; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= packed_word;
        end
    end

    // FIFO pointers and occupancy; the popped entry leaves the count at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Write sequencer: pop, hold the write through waitrequest, optional gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            avm_write     <= 1'b0;
            avm_address   <= CMD_ADDR;
            avm_writedata <= '0;
            sent_count    <= '0;
            gap_cnt       <= '0;
            busy          <= 1'b0;
        end else begin
            avm_address <= CMD_ADDR;
            case (state)
                IDLE: begin
                    if (pop) begin
                        avm_writedata <= mem[rd_ptr];
                        avm_write     <= 1'b1;
                        state         <= WRITE;
                        busy          <= 1'b1;
                    end else begin
                        busy <= (count_next != '0);
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write  <= 1'b0;
                        sent_count <= sent_count + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                            busy    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= (count_next != '0);
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= (count_next != '0);
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    avm_write <= 1'b0;
                    busy      <= (count_next != '0);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/snake_cmd_master.md
Name: snake_cmd_master

Overview:
- Avalon-MM write master that drives the HPS-style command slave port of snake_fpga from fabric logic.
- Lets on-chip sources (AI player, replay engine, test sequencer) inject snake commands in place of the HPS.
- Accepts {cmd, x, y} requests on a valid/ready interface and buffers them in a small FIFO.
- Packs each request into the 32-bit message word and issues one Avalon write per request, honouring waitrequest and an optional inter-write gap.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 0: idle cycles inserted after each completed write (0 to 15).
- CMD_ADDR, 4'd0: Avalon word address of the command register.
- CMD_OFFSET, 24: bit position of cmd field in writedata.
- X_OFFSET, 8: bit position of x field.
- Y_OFFSET, 0: bit position of y field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  FIFO can accept.
- cmd_code  in  4  command code (CMD_SNAKE_ADD, CMD_SNAKE_DEL, ...), passed through unchanged.
- cmd_x  in  9  x coordinate.
- cmd_y  in  8  y coordinate.
- avm_address  out  4  Avalon address.
- avm_write  out  1  Avalon write strobe.
- avm_writedata  out  32  packed message word.
- avm_waitrequest  in  1  slave stall.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the entry in flight.
- busy  out  1  high when the FSM is not IDLE or pending is non-zero.
- sent_count  out  16  completed writes; wraps from 0xFFFF to 0.

Behaviour:
- Reset (synchronous, active-high; all outputs registered except cmd_ready):
  - FIFO flushed; FSM enters IDLE.
  - Output values: avm_write=0, avm_address=CMD_ADDR, avm_writedata=0, pending=0, sent_count=0, busy=0, cmd_ready=0 while reset is high.
- Push:
  - cmd_ready = !full, decoded from registered occupancy only.
  - Push occurs on a clk edge with cmd_valid && cmd_ready.
  - When full, a same-cycle pop does not enable a push; ready rises the cycle after the pop.
- Packing:
  - writedata = (cmd<<CMD_OFFSET) | (x<<X_OFFSET) | (y<<Y_OFFSET).
  - Fields are zero-extended to 32 bits before shifting; all other bits are 0.
  - The packed word is stored in the FIFO.
- FSM states: IDLE, WRITE, GAP.
  - IDLE: if FIFO non-empty, pop the head, load avm_writedata, set avm_write=1, go to WRITE.
    - First write is asserted at the clock edge after the push: push at edge N, avm_write visible from edge N+1.
  - WRITE: hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1.
    - The write completes on an edge where avm_waitrequest=0.
    - On completion: sent_count+1, avm_write=0 on that edge.
    - Then go to GAP if GAP_CYCLES>0, else to IDLE.
  - Back-to-back writes with GAP_CYCLES=0: avm_write deasserts for exactly one cycle (the IDLE cycle) between writes.
  - GAP: counter loaded with GAP_CYCLES-1 on entry; decrement each cycle; go to IDLE when it reaches 0.
- Occupancy rules:
  - pending updates on the edge of each push or pop.
  - A simultaneous push and pop leaves pending unchanged.
  - The popped entry is no longer counted in pending while it is in WRITE.
- Reset mid-write:
  - avm_write drops on the reset edge; the in-flight command and all queued commands are discarded.
  - No partial state survives.
- Inputs are ignored while reset is high.

Test Plan:
- Single ADD: cmd=1, x=1, y=1, waitrequest=0.
  - One write to address 0, data 0x01000101.
  - avm_write high for exactly 1 cycle, starting the edge after the push; sent_count=1; busy returns to 0.
- DEL with stall: cmd=2, x=10, y=10, waitrequest high for 3 cycles.
  - avm_write and data 0x02000A0A held stable for 4 cycles; sent_count increments only on the final edge.
- Max coordinates: cmd=3, x=319, y=239.
  - Data 0x03013FEF; bits 31:28 = 0.
- Backpressure: hold waitrequest=1 and push 6 requests back-to-back.
  - 1 enters WRITE and 4 are queued (pending=4); cmd_ready=0 from then on.
  - Releasing waitrequest drains the queue in order; all 5 accepted words appear; the 6th is accepted after the first pop.
- Gap: GAP_CYCLES=3, push 2 requests.
  - Exactly 4 cycles with avm_write=0 between the two writes (3 GAP + 1 IDLE).
- Reset mid-write: assert reset during a stalled write with 2 queued.
  - Next edge: avm_write=0, pending=0, sent_count=0.
  - No further writes occur after reset deasserts without new pushes.
